// File: rtl/ubit_pkg.sv
// Shared definitions for the unary bitstream decoder: FSM state encoding,
// default stream-length counter width and the bipolar decode helper.
package ubit_pkg;

  localparam int CYCLE_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bipolar value of a stream: 2*ones - (len_m1 + 1), two's complement.
  // Computed at 32 bits; callers truncate to their result width, which
  // preserves the sign for any width up to 32.
  function automatic logic [31:0] bipolar_result(input logic [31:0] ones,
                                                 input logic [31:0] len_m1);
    return (ones << 1) - (len_m1 + 32'd1);
  endfunction

endpackage

// File: rtl/ubit_ones_counter.sv
// Enable-gated cycle and ones counters for one bitstream. A synchronous clear
// restarts both; tc flags that the current valid bit is the last one.
module ubit_ones_counter
  import ubit_pkg::*;
#(
  parameter int CYCLE_W = CYCLE_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic               bit_in,
  input  logic [CYCLE_W-1:0] len_m1,
  output logic [CYCLE_W:0]   ones_next,
  output logic               tc
);

  logic [CYCLE_W-1:0] cyc;
  logic [CYCLE_W:0]   ones;

  // Ones count including the bit presented this cycle, so the final bit can
  // be folded into the result in the same cycle it is sampled.
  assign ones_next = ones + {{CYCLE_W{1'b0}}, bit_in};
  assign tc        = (cyc == len_m1);

  // Counters advance only on valid bits; clear has priority over counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc  <= {CYCLE_W{1'b0}};
      ones <= {(CYCLE_W+1){1'b0}};
    end else if (clr) begin
      cyc  <= {CYCLE_W{1'b0}};
      ones <= {(CYCLE_W+1){1'b0}};
    end else if (en) begin
      cyc  <= cyc + {{(CYCLE_W-1){1'b0}}, 1'b1};
      ones <= ones_next;
    end
  end

endmodule

// File: rtl/ubit_decoder.sv
// Unary bitstream decoder: counts ones over a programmed stream length and
// presents the binary value on a valid/ready handshake.
// Build option: define UBIT_DECODER_BIPOLAR_EN for bipolar decode
// (2*ones - length, sign-extended); otherwise unipolar (ones, zero-extended).
module ubit_decoder
  import ubit_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int CYCLE_W = CYCLE_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [CYCLE_W-1:0] i_len_m1,
  input  logic               i_bit_valid,
  input  logic               i_bit,
  output logic               o_start_ready,
  output logic               o_busy,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [WIDTH-1:0]   o_result
);

  state_t             state;
  state_t             state_next;
  logic               start_acc;
  logic               load_result;
  logic [CYCLE_W-1:0] len_m1_q;
  logic [CYCLE_W:0]   ones_next;
  logic               tc;
  logic               cnt_en;
  logic [WIDTH-1:0]   result_next;

  assign cnt_en = (state == ACC) && i_bit_valid;

  ubit_ones_counter #(
    .CYCLE_W (CYCLE_W)
  ) u_counter (
    .clk       (clk),
    .rst       (rst),
    .clr       (start_acc),
    .en        (cnt_en),
    .bit_in    (i_bit),
    .len_m1    (len_m1_q),
    .ones_next (ones_next),
    .tc        (tc)
  );

`ifdef UBIT_DECODER_BIPOLAR_EN
  assign result_next = WIDTH'(bipolar_result(32'(ones_next), 32'(len_m1_q)));
`else
  assign result_next = WIDTH'(ones_next);
`endif

  // Both flags are decoded straight from the state register.
  assign o_busy  = (state == ACC);
  assign o_valid = (state == DONE);

  // Next-state logic; DONE with ready and start chains straight into ACC.
  always_comb begin
    state_next    = state;
    start_acc     = 1'b0;
    load_result   = 1'b0;
    o_start_ready = 1'b0;
    case (state)
      IDLE: begin
        o_start_ready = 1'b1;
        if (i_start) begin
          start_acc  = 1'b1;
          state_next = ACC;
        end else begin
          state_next = IDLE;
        end
      end
      ACC: begin
        if (i_bit_valid && tc) begin
          load_result = 1'b1;
          state_next  = DONE;
        end else begin
          state_next = ACC;
        end
      end
      DONE: begin
        o_start_ready = i_ready;
        if (i_ready && i_start) begin
          start_acc  = 1'b1;
          state_next = ACC;
        end else if (i_ready) begin
          state_next = IDLE;
        end else begin
          state_next = DONE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Capture the stream length when a new accumulation is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_m1_q <= {CYCLE_W{1'b0}};
    end else if (start_acc) begin
      len_m1_q <= i_len_m1;
    end
  end

  // Result register: loaded on the last valid bit, held until the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_result <= {WIDTH{1'b0}};
    end else if (load_result) begin
      o_result <= result_next;
    end
  end

endmodule

// File: tb/tb_ubit_decoder.sv
// Self-checking bench for ubit_decoder: a transaction-level model checked
// every cycle, plus directed literal checks of latency and decoded values.
module tb_ubit_decoder;

`ifdef UBIT_DECODER_BIPOLAR_EN
  localparam bit BIP = 1'b1;
`else
  localparam bit BIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic [7:0]  i_len_m1 = 8'd0;
  logic        i_bit_valid = 1'b0;
  logic        i_bit = 1'b0;
  logic        i_ready = 1'b0;
  logic        o_start_ready;
  logic        o_busy;
  logic        o_valid;
  logic [15:0] o_result;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  ubit_decoder #(.WIDTH(16), .CYCLE_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_start       (i_start),
    .i_len_m1      (i_len_m1),
    .i_bit_valid   (i_bit_valid),
    .i_bit         (i_bit),
    .o_start_ready (o_start_ready),
    .o_busy        (o_busy),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_result      (o_result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_acc;     // a stream is being collected
  bit          m_have;    // a decoded value awaits handshake
  int          m_len;     // stream length in bits
  int          m_seen;    // valid bits collected so far
  int          m_ones;    // ones collected so far
  logic [15:0] m_res;

  function automatic logic [15:0] decode(input int ones, input int len);
    int v;
    v = BIP ? (2 * ones - len) : ones;
    return v[15:0];
  endfunction

  // Model advances on the same edges as the DUT with the pre-edge inputs.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_acc = 1'b0; m_have = 1'b0; m_len = 0; m_seen = 0; m_ones = 0;
      m_res = 16'd0;
    end else if (m_acc) begin
      if (i_bit_valid) begin
        m_seen++;
        m_ones += int'(i_bit);
        if (m_seen == m_len) begin
          m_res  = decode(m_ones, m_len);
          m_acc  = 1'b0;
          m_have = 1'b1;
        end
      end
    end else if (!m_have || i_ready) begin
      m_have = 1'b0;
      if (i_start) begin
        m_acc = 1'b1; m_len = int'(i_len_m1) + 1; m_seen = 0; m_ones = 0;
      end
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    check("busy", 32'(o_busy), 32'(m_acc));
    check("valid", 32'(o_valid), 32'(m_have));
    check("start_ready", 32'(o_start_ready), 32'(!m_acc && (!m_have || i_ready)));
    check("result", 32'(o_result), 32'(m_res));
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_stream(input logic [7:0] len_m1, output int s);
    i_start = 1'b1;
    i_len_m1 = len_m1;
    s = cyc;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  // kind: 0 all ones, 1 all zeros, 2 alternating starting with 1
  task automatic send_bits(input int n, input int kind, input bit gaps);
    for (int i = 0; i < n; i++) begin
      i_bit_valid = 1'b1;
      i_bit = (kind == 0) ? 1'b1 : (kind == 1) ? 1'b0 : ((i % 2) == 0);
      @(posedge clk); #1;
      if (gaps && i < n - 1) begin
        i_bit_valid = 1'b0;
        i_bit = 1'b1;
        @(posedge clk); #1;
      end
    end
    i_bit_valid = 1'b0;
    i_bit = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int s, input int lat);
    int n;
    n = 0;
    while (!o_valid && n < 600) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 32'(cyc - s), 32'(lat));
  endtask

  task automatic accept();
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
    check("valid_after_accept", 32'(o_valid), 32'd0);
  endtask

  initial begin
    int s;
    repeat (3) @(posedge clk);
    #1;
    check("rst_start_ready", 32'(o_start_ready), 32'd1);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_result", 32'(o_result), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Full-length stream of ones.
    start_stream(8'd255, s);
    check("busy_after_start", 32'(o_busy), 32'd1);
    send_bits(256, 0, 1'b0);
    wait_valid("lat_256", s, 257);
    check("res_256", 32'(o_result), 32'd256);
    accept();

    // Alternating and all-zero 16-bit streams.
    start_stream(8'd15, s);
    send_bits(16, 2, 1'b0);
    wait_valid("lat_alt16", s, 17);
    check("res_alt16", 32'(o_result), BIP ? 32'd0 : 32'd8);
    accept();
    start_stream(8'd15, s);
    send_bits(16, 1, 1'b0);
    wait_valid("lat_zero16", s, 17);
    check("res_zero16", 32'(o_result), BIP ? 32'h0000_fff0 : 32'd0);
    accept();

    // Gapped stream: invalid cycles must not count.
    start_stream(8'd7, s);
    send_bits(8, 0, 1'b1);
    wait_valid("lat_gap8", s, 16);
    check("res_gap8", 32'(o_result), 32'd8);

    // Hold with ready low while start pulses, then chained restart.
    for (int k = 0; k < 10; k++) begin
      i_start = ((k % 2) == 0);
      i_len_m1 = 8'd5;
      @(posedge clk); #1;
      check("hold_valid", 32'(o_valid), 32'd1);
      check("hold_result", 32'(o_result), 32'd8);
    end
    i_ready = 1'b1;
    i_start = 1'b1;
    i_len_m1 = 8'd3;
    s = cyc;
    @(posedge clk); #1;
    i_ready = 1'b0;
    i_start = 1'b0;
    check("chain_busy", 32'(o_busy), 32'd1);
    check("chain_valid", 32'(o_valid), 32'd0);
    check("chain_held_result", 32'(o_result), 32'd8);
    send_bits(4, 0, 1'b0);
    wait_valid("lat_chain4", s, 5);
    check("res_chain4", 32'(o_result), 32'd4);
    accept();

    // Reset in the middle of a long stream.
    start_stream(8'd255, s);
    send_bits(100, 0, 1'b0);
    rst = 1'b1;
    #2;
    check("mid_rst_busy", 32'(o_busy), 32'd0);
    check("mid_rst_valid", 32'(o_valid), 32'd0);
    check("mid_rst_ready", 32'(o_start_ready), 32'd1);
    check("mid_rst_result", 32'(o_result), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    start_stream(8'd3, s);
    send_bits(4, 0, 1'b0);
    wait_valid("lat_post_rst", s, 5);
    check("res_post_rst", 32'(o_result), 32'd4);
    accept();

    // Single-bit stream.
    start_stream(8'd0, s);
    send_bits(1, 0, 1'b0);
    wait_valid("lat_len1", s, 2);
    check("res_len1", 32'(o_result), 32'd1);
    accept();
    repeat (3) @(posedge clk);
    #1;
    check("idle_result_held", 32'(o_result), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ubit_decoder.md
# ubit_decoder

Converts the serial product bitstream emitted by the unary multiplier array back into a binary result. Counts ones over a programmed stream length, then presents the decoded value on a valid/ready output handshake. Sits at the output edge of the uGEMM-rate PE column, one instance per output bitstream, feeding the binary accumulation/writeback path.

## Interface
- WIDTH, 16, result width; must be ≥ CYCLE_W+2.
- CYCLE_W, 8, stream-length counter width; maximum stream length is 2^CYCLE_W.

- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- i_start  input  1  start request; samples i_len_m1.
- i_len_m1  input  CYCLE_W  stream length minus one (0 → 1 cycle, 255 → 256 cycles).
- i_bit_valid  input  1  i_bit is meaningful this cycle.
- i_bit  input  1  product bit from the multiplier.
- o_start_ready  output  1  start will be accepted this cycle.
- o_busy  output  1  accumulation in progress.
- o_valid  output  1  o_result valid.
- i_ready  input  1  downstream accepts o_result.
- o_result  output  WIDTH  decoded value.

## Operation
- States: IDLE, ACC, DONE (one-hot not required).
- IDLE: o_start_ready=1. i_start → latch len_m1, clear ones and cycle counters, go ACC.
- ACC: o_busy=1. Each cycle with i_bit_valid: cycle counter +1; ones counter +i_bit. Cycles with i_bit_valid=0 are ignored, counters hold. When a valid bit is sampled with cycle counter == len_m1: go DONE, latch result.
- DONE: o_valid=1, o_result held stable. i_ready → go IDLE. i_ready and i_start in the same cycle → accept the result and start a new accumulation (go ACC directly); o_start_ready = i_ready in DONE.
- i_start in ACC, or in DONE without i_ready: ignored, no effect.
- i_bit / i_bit_valid in IDLE or DONE: ignored.
- Ones counter is CYCLE_W+1 bits; no wrap possible (max 2^CYCLE_W).
- Result arithmetic: see Configuration; sign- or zero-extended to WIDTH.

## Timing
- Reset: state=IDLE, o_valid=0, o_busy=0, o_start_ready=1, o_result=0, counters=0.
- Reset mid-ACC or mid-DONE: partial count discarded, outputs return to reset values immediately (async).
- o_busy rises the cycle after the accepted i_start.
- o_valid rises the cycle after the last valid bit is sampled; o_result is registered and valid the same cycle.
- Latency for a stream of N bits with no gaps: N+1 cycles from the start cycle to o_valid.
- o_valid falls the cycle after the i_ready handshake. o_result holds its last value until the next result.
- Back-to-back streams: zero idle cycles when i_start coincides with the i_ready handshake.

## Configuration
- UBIT_DECODER_BIPOLAR_EN defined: bipolar decode, o_result = 2·ones − (len_m1+1), two's complement, sign-extended. Matches the XNOR bipolar multiplier encoding.
- Undefined: unipolar decode, o_result = ones, zero-extended.

## Structure
- Shared package ubit_pkg: state enum typedef (IDLE/ACC/DONE), default CYCLE_W constant, function computing the bipolar result from ones and len_m1.
- One sub-module, ubit_ones_counter: enable-gated cycle and ones counters with synchronous clear and terminal-count flag. FSM and output register stay in ubit_decoder.

## Test plan
- Unipolar, len_m1=255, 256 bits all 1, no gaps → o_valid at cycle 257, o_result=256; bipolar build → o_result=256.
- Bipolar, len_m1=15, 16 bits alternating 1/0 → o_result=0; all-zero stream → o_result=−16 (0xFFF0).
- len_m1=7, i_bit_valid low every other cycle, 8 valid ones of 8 → o_valid 16 cycles after start; ignored cycles do not count.
- Result held with i_ready=0 for 10 cycles while i_start pulses → o_result stable, no restart; then i_ready with i_start in the same cycle → new ACC next cycle, o_valid drops.
- rst asserted at bit 100 of a 256-bit stream → outputs at reset values; a new stream of 4 ones (len_m1=3) decodes to 4 (unipolar), unaffected by the old count.
- len_m1=0, single bit 1 → o_valid 2 cycles after start, o_result=1 (unipolar) / 1 (bipolar).
